// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port SRAM.
// After reset an optional sweep zero-fills the array; read data is routed back by tag.
module mem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_write,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  init_done,
    output logic                  mem_chip_en,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wr_data,
    input  logic [DATA_W-1:0]     mem_rd_data
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam state_t           RESET_STATE = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};

    state_t              state_r, state_next_s;
    logic [ADDR_W-1:0]   sweep_cnt_r;
    logic                ptr_r;
    logic                init_done_r;
    logic [1:0]          tag_r [RD_LATENCY];
    logic [ADDR_W-1:0]   addr_hold_r;
    logic [DATA_W-1:0]   wdata_hold_r;

    logic [1:0]          valid_s;
    logic [1:0]          grant_s;
    logic                granted_s;
    logic                gnt_id_s;
    logic                gnt_write_s;
    logic [ADDR_W-1:0]   gnt_addr_s;
    logic [DATA_W-1:0]   gnt_wdata_s;
    logic                chip_en_s, wr_en_s, rd_en_s;
    logic [ADDR_W-1:0]   addr_s;
    logic [DATA_W-1:0]   wr_data_s;
    logic [1:0]          rsp_tag_s;
    logic [1:0]          rsp_valid_s;
    logic [DATA_W-1:0]   rsp_data_s;

    // Next-state: the sweep ends once the last address has been written.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (sweep_cnt_r == LAST_ADDR) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_INIT;
                end
            end
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = RESET_STATE;
        endcase
    end

    // Round-robin grant; only requests seen in RUN outside reset are eligible.
    always_comb begin
        valid_s = req_valid & {2{(state_r == ST_RUN) & reset_n}};
        grant_s = 2'b00;
        case (valid_s)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = ptr_r ? 2'b10 : 2'b01;
            default: grant_s = 2'b00;
        endcase
        granted_s   = |grant_s;
        gnt_id_s    = grant_s[1];
        gnt_write_s = gnt_id_s ? req_write[1] : req_write[0];
        gnt_addr_s  = gnt_id_s ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        gnt_wdata_s = gnt_id_s ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    end

    // Memory pin drive; address and write data hold their last value when idle.
    always_comb begin
        chip_en_s = 1'b0;
        wr_en_s   = 1'b0;
        rd_en_s   = 1'b0;
        addr_s    = addr_hold_r;
        wr_data_s = wdata_hold_r;
        if (!reset_n) begin
            addr_s    = {ADDR_W{1'b0}};
            wr_data_s = {DATA_W{1'b0}};
        end else if (state_r == ST_INIT) begin
            chip_en_s = 1'b1;
            wr_en_s   = 1'b1;
            addr_s    = sweep_cnt_r;
            wr_data_s = {DATA_W{1'b0}};
        end else if (granted_s) begin
            chip_en_s = 1'b1;
            addr_s    = gnt_addr_s;
            if (gnt_write_s) begin
                wr_en_s   = 1'b1;
                wr_data_s = gnt_wdata_s;
            end else begin
                rd_en_s   = 1'b1;
            end
        end else begin
            chip_en_s = 1'b0;
        end
    end

    // Control state: FSM, sweep counter, priority pointer, init flag, pin hold.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r      <= RESET_STATE;
            sweep_cnt_r  <= {ADDR_W{1'b0}};
            ptr_r        <= 1'b0;
            init_done_r  <= (INIT_CLEAR == 0) ? 1'b1 : 1'b0;
            addr_hold_r  <= {ADDR_W{1'b0}};
            wdata_hold_r <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_INIT && sweep_cnt_r != LAST_ADDR) begin
                sweep_cnt_r <= sweep_cnt_r + ADDR_W'(1);
            end
            if (state_r == ST_INIT && sweep_cnt_r == LAST_ADDR) begin
                init_done_r <= 1'b1;
            end
            if (grant_s[0]) begin
                ptr_r <= 1'b1;
            end else if (grant_s[1]) begin
                ptr_r <= 1'b0;
            end
            addr_hold_r  <= addr_s;
            wdata_hold_r <= wr_data_s;
        end
    end

    // Response tag pipeline: {read valid, requester id}, aligned to the read latency.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                tag_r[k] <= 2'b00;
            end
        end else begin
            tag_r[0] <= {granted_s & ~gnt_write_s, gnt_id_s};
            for (int k = 1; k < RD_LATENCY; k++) begin
                tag_r[k] <= tag_r[k-1];
            end
        end
    end

    // Response decode; data bus is forced to zero when no response is due.
    always_comb begin
        rsp_tag_s = tag_r[RD_LATENCY-1];
        if (reset_n && rsp_tag_s[1]) begin
            rsp_valid_s = rsp_tag_s[0] ? 2'b10 : 2'b01;
            rsp_data_s  = mem_rd_data;
        end else begin
            rsp_valid_s = 2'b00;
            rsp_data_s  = {DATA_W{1'b0}};
        end
    end

    assign req_ready   = grant_s;
    assign rsp_valid   = rsp_valid_s;
    assign rsp_data    = rsp_data_s;
    assign init_done   = init_done_r;
    assign mem_chip_en = chip_en_s;
    assign mem_wr_en   = wr_en_s;
    assign mem_rd_en   = rd_en_s;
    assign mem_addr    = addr_s;
    assign mem_wr_data = wr_data_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance A (sweep on, latency 1) and instance B (no sweep, latency 3),
// each attached to a behavioural SRAM model.
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            reset_n_a, reset_n_b;
    logic [1:0]      req_valid_a, req_write_a, req_ready_a, rsp_valid_a;
    logic [1:0]      req_valid_b, req_write_b, req_ready_b, rsp_valid_b;
    logic [2*AW-1:0] req_addr_a, req_addr_b;
    logic [2*DW-1:0] req_wdata_a, req_wdata_b;
    logic [DW-1:0]   rsp_data_a, rsp_data_b;
    logic            init_done_a, mem_chip_en_a, mem_wr_en_a, mem_rd_en_a;
    logic            init_done_b, mem_chip_en_b, mem_wr_en_b, mem_rd_en_b;
    logic [AW-1:0]   mem_addr_a, mem_addr_b;
    logic [DW-1:0]   mem_wr_data_a, mem_rd_data_a, mem_wr_data_b, mem_rd_data_b;

    logic [DW-1:0]   mem_a [1024] = '{default: 16'h5555};
    logic [DW-1:0]   mem_b [1024] = '{default: 16'h7777};
    logic [DW-1:0]   pipe_b [3];

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1), .INIT_CLEAR(1)) dut_a (
        .clock(clock), .reset_n(reset_n_a),
        .req_valid(req_valid_a), .req_write(req_write_a), .req_addr(req_addr_a),
        .req_wdata(req_wdata_a), .req_ready(req_ready_a), .rsp_valid(rsp_valid_a),
        .rsp_data(rsp_data_a), .init_done(init_done_a), .mem_chip_en(mem_chip_en_a),
        .mem_wr_en(mem_wr_en_a), .mem_rd_en(mem_rd_en_a), .mem_addr(mem_addr_a),
        .mem_wr_data(mem_wr_data_a), .mem_rd_data(mem_rd_data_a)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3), .INIT_CLEAR(0)) dut_b (
        .clock(clock), .reset_n(reset_n_b),
        .req_valid(req_valid_b), .req_write(req_write_b), .req_addr(req_addr_b),
        .req_wdata(req_wdata_b), .req_ready(req_ready_b), .rsp_valid(rsp_valid_b),
        .rsp_data(rsp_data_b), .init_done(init_done_b), .mem_chip_en(mem_chip_en_b),
        .mem_wr_en(mem_wr_en_b), .mem_rd_en(mem_rd_en_b), .mem_addr(mem_addr_b),
        .mem_wr_data(mem_wr_data_b), .mem_rd_data(mem_rd_data_b)
    );

    // SRAM model A: one-cycle read latency; non-read cycles return a marker value.
    always @(posedge clock) begin
        if (mem_chip_en_a && mem_wr_en_a) mem_a[mem_addr_a] <= mem_wr_data_a;
        mem_rd_data_a <= (mem_chip_en_a && mem_rd_en_a) ? mem_a[mem_addr_a] : 16'hDEAD;
    end

    // SRAM model B: three-cycle read latency.
    always @(posedge clock) begin
        if (mem_chip_en_b && mem_wr_en_b) mem_b[mem_addr_b] <= mem_wr_data_b;
        pipe_b[0] <= (mem_chip_en_b && mem_rd_en_b) ? mem_b[mem_addr_b] : 16'hDEAD;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign mem_rd_data_b = pipe_b[2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int bad_sweep, bad_rdy, bad_done;
        bad_sweep = 0; bad_rdy = 0; bad_done = 0;
        reset_n_a = 1'b0; reset_n_b = 1'b0;
        // A: req0 reads 0x3FF, held from reset through the sweep
        req_valid_a = 2'b01; req_write_a = 2'b00;
        req_addr_a = {10'h000, 10'h3FF}; req_wdata_a = {16'h0000, 16'h0000};
        // B: req0 writes 0x020, held through reset
        req_valid_b = 2'b01; req_write_b = 2'b01;
        req_addr_b = {10'h000, 10'h020}; req_wdata_b = {16'h0000, 16'h1234};
        step(); step();
        @(negedge clock);
        check_eq("rst_ready", req_ready_a, 32'd0);
        check_eq("rst_rsp_valid", rsp_valid_a, 32'd0);
        check_eq("rst_enables", {mem_chip_en_a, mem_wr_en_a, mem_rd_en_a}, 32'd0);
        check_eq("rst_addr", mem_addr_a, 32'd0);
        check_eq("rst_init_done", init_done_a, 32'd0);
        check_eq("b_rst_init_done", init_done_b, 32'd1);
        check_eq("b_rst_ready", req_ready_b, 32'd0);
        step();
        reset_n_a = 1'b1;

        for (int i = 0; i < 1024; i++) begin
            @(negedge clock);
            if (mem_addr_a !== AW'(i) || mem_wr_en_a !== 1'b1 || mem_chip_en_a !== 1'b1 ||
                mem_rd_en_a !== 1'b0 || mem_wr_data_a !== 16'h0000) bad_sweep++;
            if (req_ready_a !== 2'b00) bad_rdy++;
            if (init_done_a !== 1'b0) bad_done++;
            if (i == 0) check_eq("sweep_first_addr", mem_addr_a, 32'd0);
            if (i == 1023) check_eq("sweep_last_addr", mem_addr_a, 32'h3FF);
            step();
        end
        check_eq("sweep_pattern_errs", bad_sweep, 32'd0);
        check_eq("sweep_ready_errs", bad_rdy, 32'd0);
        check_eq("sweep_init_done_errs", bad_done, 32'd0);

        // First RUN cycle: held request is granted
        @(negedge clock);
        check_eq("run_init_done", init_done_a, 32'd1);
        check_eq("held_req_ready", req_ready_a, 32'h1);
        check_eq("held_req_rd_en", {mem_chip_en_a, mem_wr_en_a, mem_rd_en_a}, 32'h5);
        check_eq("held_req_addr", mem_addr_a, 32'h3FF);
        step();

        req_valid_a = 2'b10; req_write_a = 2'b10;
        req_addr_a = {10'h155, 10'h000}; req_wdata_a = {16'hBEEF, 16'h0000};
        @(negedge clock);
        check_eq("rd3ff_rsp_valid", rsp_valid_a, 32'h1);
        check_eq("rd3ff_rsp_data", rsp_data_a, 32'h0000);
        check_eq("wr155_ready", req_ready_a, 32'h2);
        check_eq("wr155_enables", {mem_chip_en_a, mem_wr_en_a, mem_rd_en_a}, 32'h6);
        check_eq("wr155_addr", mem_addr_a, 32'h155);
        check_eq("wr155_wdata", mem_wr_data_a, 32'hBEEF);
        step();

        req_write_a = 2'b00;
        @(negedge clock);
        check_eq("wr_no_rsp", rsp_valid_a, 32'h0);
        check_eq("idle_rsp_data_zero", rsp_data_a, 32'h0);
        check_eq("rd155_ready", req_ready_a, 32'h2);
        check_eq("rd155_rd_en", mem_rd_en_a, 32'h1);
        step();

        req_valid_a = 2'b00;
        @(negedge clock);
        check_eq("rd155_rsp_valid", rsp_valid_a, 32'h2);
        check_eq("rd155_rsp_data", rsp_data_a, 32'hBEEF);
        check_eq("idle_chip_en", mem_chip_en_a, 32'h0);
        check_eq("idle_addr_hold", mem_addr_a, 32'h155);
        check_eq("idle_wdata_hold", mem_wr_data_a, 32'hBEEF);
        step();

        // Preload 0x001 and 0x002; pointer ends at 0
        req_valid_a = 2'b01; req_write_a = 2'b01;
        req_addr_a = {10'h000, 10'h001}; req_wdata_a = {16'h0000, 16'h1111};
        @(negedge clock);
        check_eq("pre1_ready", req_ready_a, 32'h1);
        step();
        req_valid_a = 2'b10; req_write_a = 2'b10;
        req_addr_a = {10'h002, 10'h000}; req_wdata_a = {16'h2222, 16'h0000};
        @(negedge clock);
        check_eq("pre2_ready", req_ready_a, 32'h2);
        step();

        // Contention: both read continuously for four cycles
        req_valid_a = 2'b11; req_write_a = 2'b00; req_addr_a = {10'h002, 10'h001};
        for (int k = 0; k < 5; k++) begin
            if (k == 4) req_valid_a = 2'b00;
            @(negedge clock);
            if (k < 4) begin
                check_eq($sformatf("cont_ready_%0d", k), req_ready_a, (k % 2 == 0) ? 32'h1 : 32'h2);
                check_eq($sformatf("cont_addr_%0d", k), mem_addr_a, (k % 2 == 0) ? 32'h1 : 32'h2);
            end
            if (k == 0) check_eq("cont_rsp_none", rsp_valid_a, 32'h0);
            if (k > 0) begin
                check_eq($sformatf("cont_rsp_valid_%0d", k), rsp_valid_a, (k % 2 == 1) ? 32'h1 : 32'h2);
                check_eq($sformatf("cont_rsp_data_%0d", k), rsp_data_a, (k % 2 == 1) ? 32'h1111 : 32'h2222);
            end
            step();
        end

        // Reset one cycle after a read grant on A
        req_valid_a = 2'b01; req_addr_a = {10'h000, 10'h001};
        @(negedge clock);
        check_eq("a_midrd_ready", req_ready_a, 32'h1);
        step();
        reset_n_a = 1'b0; req_valid_a = 2'b00;
        @(negedge clock);
        check_eq("a_midrst_rsp", rsp_valid_a, 32'h0);
        check_eq("a_midrst_chip_en", mem_chip_en_a, 32'h0);
        step();
        reset_n_a = 1'b1; req_valid_a = 2'b01;
        @(negedge clock);
        check_eq("a_reinit_rsp", rsp_valid_a, 32'h0);
        check_eq("a_reinit_ready", req_ready_a, 32'h0);
        check_eq("a_reinit_addr0", mem_addr_a, 32'h0);
        check_eq("a_reinit_wr_en", mem_wr_en_a, 32'h1);
        check_eq("a_reinit_done", init_done_a, 32'h0);
        step();
        @(negedge clock);
        check_eq("a_reinit_addr1", mem_addr_a, 32'h1);
        check_eq("a_reinit_rsp2", rsp_valid_a, 32'h0);
        step();

        // B: no sweep, write granted in first cycle after release
        reset_n_b = 1'b1;
        @(negedge clock);
        check_eq("b_first_init_done", init_done_b, 32'h1);
        check_eq("b_first_ready", req_ready_b, 32'h1);
        check_eq("b_first_wr_en", mem_wr_en_b, 32'h1);
        check_eq("b_first_addr", mem_addr_b, 32'h020);
        check_eq("b_first_wdata", mem_wr_data_b, 32'h1234);
        step();
        for (int k = 0; k < 4; k++) begin
            req_addr_b = {10'h000, AW'(16 + k)};
            req_wdata_b = {16'h0000, 16'h4010 + 16'(k)};
            step();
        end
        // Back-to-back reads 0x010..0x013 with three-cycle latency
        req_write_b = 2'b00;
        for (int t = 0; t < 8; t++) begin
            if (t < 4) req_addr_b = {10'h000, AW'(16 + t)};
            else req_valid_b = 2'b00;
            @(negedge clock);
            if (t < 4) check_eq($sformatf("b_rd_ready_%0d", t), req_ready_b, 32'h1);
            if (t >= 3 && t <= 6) begin
                check_eq($sformatf("b_rsp_valid_%0d", t), rsp_valid_b, 32'h1);
                check_eq($sformatf("b_rsp_data_%0d", t), rsp_data_b, 32'h4010 + 32'(t - 3));
            end else begin
                check_eq($sformatf("b_rsp_idle_%0d", t), rsp_valid_b, 32'h0);
            end
            step();
        end

        // Reset B while a read is in flight
        req_valid_b = 2'b01; req_addr_b = {10'h000, 10'h011};
        @(negedge clock);
        check_eq("b_midrd_ready", req_ready_b, 32'h1);
        step();
        reset_n_b = 1'b0; req_valid_b = 2'b00;
        @(negedge clock);
        check_eq("b_midrst_rsp", rsp_valid_b, 32'h0);
        check_eq("b_midrst_addr", mem_addr_b, 32'h0);
        step();
        reset_n_b = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clock);
            check_eq($sformatf("b_dropped_rsp_%0d", t), rsp_valid_b, 32'h0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
